tx_serializer_fifo: RTL and testbench
=====================================

TX_SERIALIZER_FIFO -- requirements
Module: tx_serializer_fifo

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, bytes per input word (1..8).
REQ-002 SHALL have parameter DEPTH, default 32, word entries; power of two, >=2.
REQ-003 SHALL have parameter LSB_FIRST, default 0; 0 = most-significant byte sent first, 1 = least-significant first.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  8*WORD_BYTES  word to enqueue.
REQ-007 SHALL have port in_valid  input  1  in_data is offered this cycle.
REQ-008 SHALL have port in_ready  output  1  a word can be accepted this cycle.
REQ-009 SHALL have port out_data  output  8  current byte to the UART sender.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-011 SHALL have port out_ready  input  1  sender takes out_data this cycle.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  words stored, including a partially sent head word.
REQ-013 SHALL have ports empty, full  output  1 each  count==0, count==DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: a word was offered while full.

Function
REQ-015 SHALL accept a word iff in_valid && in_ready; in_ready SHALL equal !full.
REQ-016 SHALL write accepted words at tail, increment tail modulo DEPTH.
REQ-017 SHALL drive out_valid = !empty; out_data = byte byte_idx of the head word in the order set by LSB_FIRST.
REQ-018 SHALL advance byte_idx (0..WORD_BYTES-1) on each out_valid && out_ready.
REQ-019 SHALL, on the handshake of byte WORD_BYTES-1, reset byte_idx to 0, increment head modulo DEPTH, decrement count.
REQ-020 SHALL show a word written into an empty FIFO at edge N with out_valid=1 in the cycle after edge N (1-cycle latency); no bypass in the same cycle.
REQ-021 SHALL hold out_data and byte_idx stable while out_valid && !out_ready.
REQ-022 SHALL, on simultaneous accept and final-byte pop, leave count unchanged and move both pointers.
REQ-023 SHALL refuse writes when full, even if the final byte pops the same cycle; accepted again next cycle.
REQ-024 SHALL set overflow when in_valid && full; word discarded, cleared only by reset.
REQ-025 SHALL ignore out_ready while empty; byte_idx stays 0.
REQ-026 SHALL keep count arithmetic at $clog2(DEPTH)+1 bits so count==DEPTH is representable; pointers $clog2(DEPTH) bits, natural wrap.
REQ-027 SHALL, when WORD_BYTES==1, pop a word on every out handshake.

Reset
REQ-028 SHALL on reset clear head, tail, count, byte_idx, overflow; outputs: out_valid=0, empty=1, full=0, in_ready=1, count=0.
REQ-029 SHALL on reset mid-word discard the partial word; storage contents need not be cleared.
REQ-030 SHALL give reset priority over any simultaneous handshake in that cycle.

Structure
REQ-031 SHALL place BYTE_W=8 constant and a byte_order_t enum (MSB_FIRST, LSB_FIRST) in shared package uart_pkg.
REQ-032 SHALL be a single module; storage as an array of words inferable as RAM/regs; no sub-module.

Verification
REQ-033 SHALL test: reset, write 0x11223344 -> next cycle out_valid=1; bytes 0x11,0x22,0x33,0x44 with out_ready=1; then empty=1.
REQ-034 SHALL test: LSB_FIRST=1, same word -> bytes 0x44,0x33,0x22,0x11.
REQ-035 SHALL test: DEPTH=4, write 5 words, out_ready=0 -> full=1, in_ready=0 after 4th, overflow=1, count=4; drain returns first 4 words in order.
REQ-036 SHALL test: full FIFO, final byte pop with in_valid=1 same cycle -> write refused, count=3, in_ready=1 next cycle.
REQ-037 SHALL test: out_ready toggled 1/0 each cycle over 3 words -> no byte lost or repeated; pointer wrap past DEPTH-1 with 10 words into DEPTH=4.
REQ-038 SHALL test: reset asserted after 2 bytes of a word sent -> out_valid=0, count=0 next cycle; new word sends from its first byte.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte-width constant and byte-order type for the UART transmit path
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } byte_order_t;

endpackage

// File: rtl/tx_serializer_fifo.sv
// rtl/tx_serializer_fifo.sv - word FIFO that hands its head word to the UART sender one byte at a time
module tx_serializer_fifo #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 32,
    parameter int LSB_FIRST  = 0
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [uart_pkg::BYTE_W*WORD_BYTES-1:0] in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [uart_pkg::BYTE_W-1:0]          out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(DEPTH):0]               count,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 overflow
);

    import uart_pkg::*;

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // A one-byte word still needs a (constant zero) index register.
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam byte_order_t ORDER = (LSB_FIRST != 0) ? uart_pkg::LSB_FIRST : uart_pkg::MSB_FIRST;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] byte_idx;
    logic             overflow_q;

    logic             push;
    logic             pop_byte;
    logic             last_byte;
    logic             pop_word;
    logic [WORD_W-1:0] head_word;
    logic [IDX_W-1:0] byte_sel;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop in the same cycle does not free a slot for the incoming word:
    // in_ready depends only on the registered count.
    assign push      = in_valid && in_ready;
    assign pop_byte  = out_valid && out_ready;
    assign last_byte = (byte_idx == LAST_IDX);
    assign pop_word  = pop_byte && last_byte;

    assign head_word = mem[head];

    // Pick the byte of the head word that is due next, in the configured order.
    always_comb begin
        byte_sel = (ORDER == uart_pkg::MSB_FIRST) ? (LAST_IDX - byte_idx) : byte_idx;
        out_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (IDX_W'(i) == byte_sel) begin
                out_data = head_word[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Word storage has no reset so it can map onto RAM; stale entries are never read.
    always_ff @(posedge CLK) begin
        if (push && !reset) begin
            mem[tail] <= in_data;
        end
    end

    // Pointers, occupancy, byte position within the head word, and sticky overflow.
    always_ff @(posedge CLK) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            byte_idx   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end

            if (pop_byte) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    head     <= head + PTR_W'(1);
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end

            case ({push, pop_word})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (in_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_serializer_fifo.sv
// tb/tb_tx_serializer_fifo.sv - self-checking bench for tx_serializer_fifo against a word-queue model
module tb_tx_serializer_fifo;

    localparam int WB = 4;
    localparam int D0 = 4;
    localparam int D1 = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            reset;
    logic [1:0][31:0] in_data;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0][7:0] out_data;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0]      empty;
    logic [1:0]      full;
    logic [1:0]      overflow;
    logic [2:0]      count0;
    logic [5:0]      count1;

    tx_serializer_fifo #(.WORD_BYTES(WB), .DEPTH(D0), .LSB_FIRST(0)) dut_msb (
        .CLK(CLK), .reset(reset),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .count(count0), .empty(empty[0]), .full(full[0]), .overflow(overflow[0])
    );

    tx_serializer_fifo #(.WORD_BYTES(WB), .DEPTH(D1), .LSB_FIRST(1)) dut_lsb (
        .CLK(CLK), .reset(reset),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .count(count1), .empty(empty[1]), .full(full[1]), .overflow(overflow[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of stored words per DUT, bytes already sent from the head, sticky overflow.
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    int          sent [2];
    bit          ovf  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_size(input bit d);
        return d ? mq1.size() : mq0.size();
    endfunction

    function automatic logic [31:0] m_head(input bit d);
        return d ? mq1[0] : mq0[0];
    endfunction

    function automatic int m_depth(input bit d);
        return d ? D1 : D0;
    endfunction

    // Byte k of a word in transmit order: dut 0 sends MSB first, dut 1 LSB first.
    function automatic logic [7:0] exp_byte(input bit d, input logic [31:0] w, input int k);
        int          sh;
        logic [31:0] t;
        sh = d ? 8 * k : 8 * (WB - 1 - k);
        t  = w >> sh;
        return t[7:0];
    endfunction

    task automatic check_dut(input bit d);
        int          n;
        string       s;
        logic [31:0] cnt;
        n   = m_size(d);
        s   = d ? "lsb" : "msb";
        cnt = d ? 32'(count1) : 32'(count0);
        check_eq({s, ".out_valid"}, 32'(out_valid[d]), 32'(n > 0));
        if (n > 0)
            check_eq({s, ".out_data"}, 32'(out_data[d]), 32'(exp_byte(d, m_head(d), sent[d])));
        check_eq({s, ".count"}, cnt, 32'(n));
        check_eq({s, ".empty"}, 32'(empty[d]), 32'(n == 0));
        check_eq({s, ".full"}, 32'(full[d]), 32'(n == m_depth(d)));
        check_eq({s, ".in_ready"}, 32'(in_ready[d]), 32'(n < m_depth(d)));
        check_eq({s, ".overflow"}, 32'(overflow[d]), 32'(ovf[d]));
    endtask

    task automatic model_edge(input bit d);
        int n;
        n = m_size(d);
        if (reset) begin
            if (d) mq1.delete(); else mq0.delete();
            sent[d] = 0;
            ovf[d]  = 1'b0;
        end else begin
            if (in_valid[d] && n == m_depth(d)) ovf[d] = 1'b1;
            if (n > 0 && out_ready[d]) begin
                sent[d]++;
                if (sent[d] == WB) begin
                    sent[d] = 0;
                    if (d) void'(mq1.pop_front()); else void'(mq0.pop_front());
                end
            end
            if (in_valid[d] && n < m_depth(d)) begin
                if (d) mq1.push_back(in_data[d]); else mq0.push_back(in_data[d]);
            end
        end
    endtask

    // Compare both DUTs with the model, advance the model, then cross one rising edge.
    task automatic step();
        check_dut(1'b0);
        check_dut(1'b1);
        model_edge(1'b0);
        model_edge(1'b1);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_pulse();
        in_valid  = '0;
        out_ready = '0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  m_exp [4];
        logic [7:0]  l_exp [4];
        logic [31:0] w5    [5];
        logic [31:0] w10   [10];
        logic [7:0]  got_b [$];
        logic [31:0] got_w;
        int          wr;
        int          cyc;

        m_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        l_exp = '{8'h44, 8'h33, 8'h22, 8'h11};
        sent  = '{0, 0};
        ovf   = '{1'b0, 1'b0};

        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = '0;
        @(posedge CLK);
        #1;
        step();
        reset = 1'b0;
        check_eq("rst.msb.empty", 32'(empty[0]), 32'd1);
        check_eq("rst.lsb.in_ready", 32'(in_ready[1]), 32'd1);
        check_eq("rst.msb.count", 32'(count0), 32'd0);

        // One word through each byte order.
        in_data[0] = 32'h11223344;
        in_data[1] = 32'h11223344;
        in_valid   = 2'b11;
        step();
        in_valid   = '0;
        check_eq("t033.valid_next", 32'(out_valid[0]), 32'd1);
        check_eq("t034.valid_next", 32'(out_valid[1]), 32'd1);
        out_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            check_eq("t033.byte", 32'(out_data[0]), 32'(m_exp[k]));
            check_eq("t034.byte", 32'(out_data[1]), 32'(l_exp[k]));
            step();
        end
        out_ready = '0;
        check_eq("t033.empty", 32'(empty[0]), 32'd1);
        check_eq("t034.empty", 32'(empty[1]), 32'd1);

        // Five words into a four-deep FIFO with the sender stalled.
        for (int i = 0; i < 5; i++) begin
            w5[i]       = $urandom;
            in_data[0]  = w5[i];
            in_valid[0] = 1'b1;
            step();
            if (i == 3) begin
                check_eq("t035.full", 32'(full[0]), 32'd1);
                check_eq("t035.in_ready", 32'(in_ready[0]), 32'd0);
            end
        end
        in_valid[0] = 1'b0;
        check_eq("t035.overflow", 32'(overflow[0]), 32'd1);
        check_eq("t035.count", 32'(count0), 32'd4);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got_w = '0;
            for (int k = 0; k < 4; k++) begin
                got_w = {got_w[23:0], out_data[0]};
                step();
            end
            check_eq("t035.drain_word", got_w, w5[i]);
        end
        out_ready[0] = 1'b0;
        check_eq("t035.empty", 32'(empty[0]), 32'd1);
        reset_pulse();

        // Final-byte pop of a full FIFO does not open a slot in the same cycle.
        for (int i = 0; i < 4; i++) begin
            in_data[0]  = $urandom;
            in_valid[0] = 1'b1;
            step();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        in_valid[0] = 1'b1;
        in_data[0]  = 32'hDEADBEEF;
        check_eq("t036.in_ready_full", 32'(in_ready[0]), 32'd0);
        step();
        in_valid[0] = 1'b0;
        check_eq("t036.count", 32'(count0), 32'd3);
        check_eq("t036.in_ready_next", 32'(in_ready[0]), 32'd1);
        for (int k = 0; k < 12; k++) step();
        reset_pulse();

        // Toggling sender over ten words, wrapping the pointers of the four-deep FIFO.
        for (int i = 0; i < 10; i++) w10[i] = $urandom;
        wr  = 0;
        cyc = 0;
        while ((wr < 10 || got_b.size() < 40) && cyc < 400) begin
            in_valid[0] = (wr < 10);
            if (wr < 10) in_data[0] = w10[wr];
            out_ready[0] = cyc[0];
            if (out_valid[0] && out_ready[0]) got_b.push_back(out_data[0]);
            if (in_valid[0] && in_ready[0]) wr++;
            step();
            cyc++;
        end
        in_valid  = '0;
        out_ready = '0;
        check_eq("t037.bytes_seen", 32'(got_b.size()), 32'd40);
        for (int i = 0; i < got_b.size() && i < 40; i++)
            check_eq("t037.byte", 32'(got_b[i]), 32'(exp_byte(1'b0, w10[i / 4], i % 4)));

        // Reset in the middle of a word, with handshakes offered during the reset cycle.
        in_data[0]  = 32'hCAFEF00D;
        in_valid[0] = 1'b1;
        step();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        step();
        step();
        reset       = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h55667788;
        step();
        reset        = 1'b0;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check_eq("t038.out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("t038.count", 32'(count0), 32'd0);
        in_data[0]  = 32'hA1B2C3D4;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        check_eq("t038.first_byte", 32'(out_data[0]), 32'hA1);
        out_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        out_ready[0] = 1'b0;

        // Random traffic on both instances with rare resets.
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            in_valid[0]  = ($urandom_range(0, 2) != 0);
            in_valid[1]  = ($urandom_range(0, 1) != 0);
            in_data[0]   = $urandom;
            in_data[1]   = $urandom;
            out_ready[0] = ($urandom_range(0, 3) == 0);
            out_ready[1] = ($urandom_range(0, 2) != 0);
            step();
        end
        reset_pulse();
        check_dut(1'b0);
        check_dut(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
